mul_final_stage: RTL and testbench

Back end of the 64-bit Booth multiplier: accepts the 128-bit carry-save pair emitted by the 33-input Wallace compression tree and resolves it with a carry-propagate add. It then selects and formats the architectural result. It is a two-stage valid/ready pipeline between the compression tree and the EXU writeback mux, with flush support for pipeline kills.

---
 rtl/mul_pkg.sv | 32 +++
 rtl/mul_final_stage_if.sv | 38 +++
 rtl/mul_cpa64.sv | 16 +
 rtl/mul_final_stage.sv | 185 ++++++++++++++++++
 tb/tb_mul_final_stage.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: definitions shared by the multiplier back end, the Booth generator
// and the EXU decode.
//   MUL_PROD_W  full product width (carry-save rows are this wide)
//   MUL_XLEN    architectural result width
//   mul_sel_e   result select carried with each op; encoding 3 is reserved
//               and formats like MUL_LOW
//   mul_format  picks and formats the architectural result from a product
package mul_pkg;

    localparam int MUL_PROD_W = 128;
    localparam int MUL_XLEN   = 64;

    typedef enum logic [1:0] {
        MUL_LOW  = 2'd0,
        MUL_HIGH = 2'd1,
        MUL_WORD = 2'd2
    } mul_sel_e;

    function automatic logic [MUL_XLEN-1:0] mul_format(
        input logic [MUL_PROD_W-1:0] prod,
        input logic [1:0]            op
    );
        logic [MUL_XLEN-1:0] res;
        case (op)
            MUL_HIGH: res = prod[MUL_PROD_W-1:MUL_XLEN];
            MUL_WORD: res = {{32{prod[31]}}, prod[31:0]};
            default:  res = prod[MUL_XLEN-1:0];   // LOW and reserved encoding
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mul_final_stage_if.sv
// mul_final_stage_if: input and output valid/ready channels of the multiplier
// back end.
//   in_valid/in_ready   carry-save pair handshake from the compression tree
//   in_sum, in_carry    128-bit carry-save rows
//   in_op               result select (mul_sel_e encoding)
//   in_tag              opaque destination tag
//   out_valid/out_ready result handshake towards the writeback mux
//   out_result          formatted 64-bit result
//   out_tag             tag travelling with the result
// Modports: slave = the multiplier back end, master = the surrounding logic.
interface mul_final_stage_if #(
    parameter int TAG_W = 5
);
    import mul_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [MUL_PROD_W-1:0] in_sum;
    logic [MUL_PROD_W-1:0] in_carry;
    logic [1:0]            in_op;
    logic [TAG_W-1:0]      in_tag;

    logic                  out_valid;
    logic                  out_ready;
    logic [MUL_XLEN-1:0]   out_result;
    logic [TAG_W-1:0]      out_tag;

    modport master (
        output in_valid, in_sum, in_carry, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_sum, in_carry, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );

endinterface

// File: rtl/mul_cpa64.sv
// mul_cpa64: 64-bit carry-propagate adder with carry in and carry out.
//   a, b   addends
//   cin    carry into bit 0
//   sum    a + b + cin, low 64 bits
//   cout   carry out of bit 63
module mul_cpa64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {64'd0, cin};

endmodule

// File: rtl/mul_final_stage.sv
// mul_final_stage: back end of the 64-bit Booth multiplier. Resolves the
// carry-save pair from the Wallace tree with a carry-propagate add, then
// selects/formats the architectural result. Two-stage valid/ready pipeline
// (stage A, stage B); the output comes straight from the stage B registers.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   flush  kills every in-flight op and any input offered in the same cycle
//   bus    mul_final_stage_if.slave (input and output channels)
//
// Build option MUL_SPLIT_ADD_EN:
//   defined   - stage A adds bits 63:0 and registers the low sum plus carry,
//               stage B adds bits 127:64 with that carry, then formats.
//   undefined - stage A performs the whole 128-bit add, stage B formats only.
// Latency, handshake and results are the same either way.
module mul_final_stage
    import mul_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    mul_final_stage_if.slave   bus
);

    localparam int HALF = MUL_XLEN;

    // handshake
    logic b_accept;
    logic a_advance;
    logic in_ready_w;
    logic in_fire;

    // stage valids
    logic va_d, va_q;
    logic vb_d, vb_q;

    // stage A payload common to both builds
    logic [1:0]       a_op_d,  a_op_q;
    logic [TAG_W-1:0] a_tag_d, a_tag_q;

    // stage B (output) registers
    logic [MUL_XLEN-1:0] b_result_d, b_result_q;
    logic [TAG_W-1:0]    b_tag_d,    b_tag_q;

    // adder halves
    logic [HALF-1:0] lo_sum;
    logic            lo_cout;
    logic [HALF-1:0] hi_sum;
    logic            unused_hi_cout;   // carry out of bit 127 is dropped

    // product as seen by the stage B formatter
    logic [MUL_PROD_W-1:0] prod_b;

`ifdef MUL_SPLIT_ADD_EN
    logic [HALF-1:0] a_lo_d,       a_lo_q;
    logic            a_cy_d,       a_cy_q;
    logic [HALF-1:0] a_sum_hi_d,   a_sum_hi_q;
    logic [HALF-1:0] a_carry_hi_d, a_carry_hi_q;

    mul_cpa64 u_cpa_lo (
        .a    (bus.in_sum[HALF-1:0]),
        .b    (bus.in_carry[HALF-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    // upper half is resolved one stage later from the registered carry
    mul_cpa64 u_cpa_hi (
        .a    (a_sum_hi_q),
        .b    (a_carry_hi_q),
        .cin  (a_cy_q),
        .sum  (hi_sum),
        .cout (unused_hi_cout)
    );

    assign prod_b = {hi_sum, a_lo_q};
`else
    logic [MUL_PROD_W-1:0] a_prod_d, a_prod_q;

    mul_cpa64 u_cpa_lo (
        .a    (bus.in_sum[HALF-1:0]),
        .b    (bus.in_carry[HALF-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    // halves chained combinationally: a full 128-bit ripple in stage A
    mul_cpa64 u_cpa_hi (
        .a    (bus.in_sum[MUL_PROD_W-1:HALF]),
        .b    (bus.in_carry[MUL_PROD_W-1:HALF]),
        .cin  (lo_cout),
        .sum  (hi_sum),
        .cout (unused_hi_cout)
    );

    assign prod_b = a_prod_q;
`endif

    always_comb begin
        b_accept   = !vb_q || bus.out_ready;
        a_advance  = va_q && b_accept;
        in_ready_w = !va_q || b_accept;
        // flush wins over accept: the offered op is dropped, not captured
        in_fire    = bus.in_valid && in_ready_w && !flush;

        if (flush) begin
            va_d = 1'b0;
            vb_d = 1'b0;
        end else begin
            va_d = in_fire || (va_q && !a_advance);
            vb_d = a_advance || (vb_q && !bus.out_ready);
        end

        a_op_d     = a_op_q;
        a_tag_d    = a_tag_q;
        b_result_d = b_result_q;
        b_tag_d    = b_tag_q;
`ifdef MUL_SPLIT_ADD_EN
        a_lo_d       = a_lo_q;
        a_cy_d       = a_cy_q;
        a_sum_hi_d   = a_sum_hi_q;
        a_carry_hi_d = a_carry_hi_q;
`else
        a_prod_d     = a_prod_q;
`endif

        if (in_fire) begin
            a_op_d  = bus.in_op;
            a_tag_d = bus.in_tag;
`ifdef MUL_SPLIT_ADD_EN
            a_lo_d       = lo_sum;
            a_cy_d       = lo_cout;
            a_sum_hi_d   = bus.in_sum[MUL_PROD_W-1:HALF];
            a_carry_hi_d = bus.in_carry[MUL_PROD_W-1:HALF];
`else
            a_prod_d     = {hi_sum, lo_sum};
`endif
        end

        if (a_advance) begin
            b_result_d = mul_format(prod_b, a_op_q);
            b_tag_d    = a_tag_q;
        end
    end

    // control state and the visible output registers are reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            va_q       <= 1'b0;
            vb_q       <= 1'b0;
            b_result_q <= '0;
            b_tag_q    <= '0;
        end else begin
            va_q       <= va_d;
            vb_q       <= vb_d;
            b_result_q <= b_result_d;
            b_tag_q    <= b_tag_d;
        end
    end

    // stage A payload only matters while va_q is set, so it is not reset
    always_ff @(posedge clk) begin
        a_op_q  <= a_op_d;
        a_tag_q <= a_tag_d;
`ifdef MUL_SPLIT_ADD_EN
        a_lo_q       <= a_lo_d;
        a_cy_q       <= a_cy_d;
        a_sum_hi_q   <= a_sum_hi_d;
        a_carry_hi_q <= a_carry_hi_d;
`else
        a_prod_q     <= a_prod_d;
`endif
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = vb_q;
    assign bus.out_result = b_result_q;
    assign bus.out_tag    = b_tag_q;

endmodule

// File: tb/tb_mul_final_stage.sv
// tb_mul_final_stage: scoreboard bench for mul_final_stage. Accepted inputs
// push a reference result into a queue; a separate monitor pops and compares
// on every output transfer and checks output stability under backpressure.
module tb_mul_final_stage;
    import mul_pkg::*;

    localparam int TAG_W = 5;

    typedef struct packed {
        logic [63:0]      result;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   ready_mode = 0;   // 0: out_ready low, 1: high, 2: random

    always #5 clk = ~clk;

    mul_final_stage_if #(.TAG_W(TAG_W)) bus ();

    mul_final_stage #(.TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   delivered = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: full product modulo 2^128, then pick the architectural view.
    function automatic logic [63:0] ref_model(input logic [127:0] s, input logic [127:0] c,
                                              input logic [1:0] op);
        logic [127:0] p;
        logic [127:0] hi;
        longint       w;
        p  = s + c;
        hi = p >> 64;
        w  = longint'(int'(p[31:0]));
        case (op)
            2'd1:    return hi[63:0];
            2'd2:    return w;
            default: return p[63:0];
        endcase
    endfunction

    // out_ready driver (single process owns the signal)
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // scoreboard producer: record every accepted input
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(exp_t'{result: ref_model(bus.in_sum, bus.in_carry, bus.in_op),
                                   tag: bus.in_tag});
        end
    end

    // monitor: compare transfers, check stability while stalled
    logic             held = 1'b0;
    logic [63:0]      held_res;
    logic [TAG_W-1:0] held_tag;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid) begin
            if (held) begin
                check("hold_result", bus.out_result, held_res);
                check("hold_tag", 64'(bus.out_tag), 64'(held_tag));
            end
            if (bus.out_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual tag=%0d result=%h required=no output",
                             bus.out_tag, bus.out_result);
                end else begin
                    e = exp_q.pop_front();
                    check("result", bus.out_result, e.result);
                    check("tag", 64'(bus.out_tag), 64'(e.tag));
                    delivered++;
                    $display("OUT tag=%0d result=%h expected=%h", bus.out_tag, bus.out_result, e.result);
                end
            end else begin
                held     = 1'b1;
                held_res = bus.out_result;
                held_tag = bus.out_tag;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic present(input logic [127:0] s, input logic [127:0] c,
                           input logic [1:0] op, input logic [TAG_W-1:0] tag);
        bus.in_valid = 1'b1;
        bus.in_sum   = s;
        bus.in_carry = c;
        bus.in_op    = op;
        bus.in_tag   = tag;
    endtask

    // Offer one op until accepted (bounded); returns 1 ns after the accept edge.
    task automatic send(input logic [127:0] s, input logic [127:0] c,
                        input logic [1:0] op, input logic [TAG_W-1:0] tag);
        bit acc = 1'b0;
        present(s, c, op, tag);
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready && !flush;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not accepted required=accepted tag=%0d", tag);
        end
    endtask

    // Wait (bounded) for the next output and compare against constants.
    task automatic expect_out(input string name, input logic [63:0] res, input logic [TAG_W-1:0] tag);
        bit seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check({name, "_valid"}, 64'(seen), 64'd1);
        if (seen) begin
            check(name, bus.out_result, res);
            check({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] LOW_ONES = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;

    initial begin
        int start_cnt;
        bus.in_valid = 1'b0;
        bus.in_sum   = '0;
        bus.in_carry = '0;
        bus.in_op    = 2'd0;
        bus.in_tag   = '0;

        // reset
        ready_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_result", bus.out_result, 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        rst_n = 1'b1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // basic op and two-register latency
        send(128'd3, 128'd5, 2'd0, 5'd7);
        check("lat_not_yet", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        check("basic_result", bus.out_result, 64'd8);
        check("basic_tag", 64'(bus.out_tag), 64'd7);
        @(posedge clk);
        #1;

        // carry crossing from the low half into the high half
        send(LOW_ONES, 128'd1, 2'd1, 5'd2);
        expect_out("cross_high", 64'd1, 5'd2);
        send(LOW_ONES, 128'd1, 2'd0, 5'd3);
        expect_out("cross_low", 64'd0, 5'd3);
        send(LOW_ONES, 128'd1, 2'd3, 5'd4);
        expect_out("reserved_as_low", 64'd0, 5'd4);

        // WORD sign extension
        send(128'h8000_0000, 128'd0, 2'd2, 5'd5);
        expect_out("word_neg", 64'hFFFF_FFFF_8000_0000, 5'd5);
        send(128'h7FFF_FFFF, 128'd0, 2'd2, 5'd6);
        expect_out("word_pos", 64'h0000_0000_7FFF_FFFF, 5'd6);

        // backpressure: tags 1,2,3 with out_ready low
        ready_mode = 0;
        @(posedge clk);
        #1;
        start_cnt = delivered;
        send(128'h1111, 128'h1, 2'd0, 5'd1);
        send(128'h2222, 128'h2, 2'd0, 5'd2);
        present(128'h3333, 128'h3, 2'd0, 5'd3);
        @(negedge clk);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_out_tag", 64'(bus.out_tag), 64'd1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        ready_mode = 1;
        send(128'h3333, 128'h3, 2'd0, 5'd3);
        repeat (5) @(posedge clk);
        #1;
        check("bp_delivered", 64'(delivered - start_cnt), 64'd3);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // flush with both stages full and a third op offered
        ready_mode = 0;
        @(posedge clk);
        #1;
        start_cnt = delivered;
        send(128'hA, 128'h0, 2'd0, 5'd10);
        send(128'hB, 128'h0, 2'd0, 5'd11);
        present(128'hC, 128'h0, 2'd0, 5'd12);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        // flush while the offered op would otherwise be accepted
        send(128'hD, 128'h0, 2'd0, 5'd13);
        present(128'hE, 128'h0, 2'd0, 5'd14);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        ready_mode   = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("flush_quiet", 64'(bus.out_valid), 64'd0);
        end
        check("flush_none_delivered", 64'(delivered - start_cnt), 64'd0);
        send(128'h40, 128'h2, 2'd0, 5'd15);
        expect_out("after_flush", 64'h42, 5'd15);

        // reset with both stages full
        ready_mode = 0;
        @(posedge clk);
        #1;
        send(128'h55, 128'h1, 2'd0, 5'd20);
        send(128'h66, 128'h1, 2'd0, 5'd21);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mrst_out_result", bus.out_result, 64'd0);
        check("mrst_out_tag", 64'(bus.out_tag), 64'd0);
        check("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        ready_mode = 1;
        start_cnt  = delivered;
        repeat (4) @(posedge clk);
        #1;
        check("mrst_none_delivered", 64'(delivered - start_cnt), 64'd0);

        // randomized traffic with random backpressure
        ready_mode = 2;
        for (int n = 0; n < 300; n++) begin
            logic [127:0] s;
            logic [127:0] c;
            s = {$urandom, $urandom, $urandom, $urandom};
            c = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) begin
                s = LOW_ONES;
                c = 128'(s[3:0]) + 128'd1;
            end
            send(s, c, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        ready_mode = 1;
        repeat (10) @(posedge clk);
        #1;
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
